// File: rtl/wb_trace_gen.sv
// Trace producer on the CPU write-back debug port: qualifying register writes become
// {pc, wnum, wdata_v, seq} records on a FIFO-backed valid/ready stream. Macro: TRACE_SHADOW_FILTER_EN.
module wb_trace_gen #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [63:0]              debug_wb_pc,
    input  logic [7:0]               debug_wb_rf_wen,
    input  logic [4:0]               debug_wb_rf_wnum,
    input  logic [63:0]              debug_wb_rf_wdata,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output logic [31:0]              trace_pc,
    output logic [4:0]               trace_wnum,
    output logic [63:0]              trace_wdata,
    output logic [CNT_W-1:0]         trace_seq,
    output logic                     trace_overflow,
    output logic [$clog2(DEPTH):0]   trace_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = 32 + 5 + 64 + CNT_W;

    logic [63:0]     wdata_v;
    logic            candidate;
    logic            qualify;
    logic [CNT_W-1:0] seq_q, seq_d;
    logic [AW:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic            overflow_q, overflow_d;
    logic            empty, full, push, pop;
    logic [RW-1:0]   mem_q [DEPTH];
    logic [RW-1:0]   head;
    logic            unused_pc_hi;

    assign unused_pc_hi = ^debug_wb_pc[63:32];

    always_comb begin
        wdata_v = '0;
        for (int i = 0; i < 8; i++) begin
            wdata_v[8*i +: 8] = debug_wb_rf_wdata[8*i +: 8] & {8{debug_wb_rf_wen[i]}};
        end
    end

    assign candidate = (|debug_wb_rf_wen) && (debug_wb_rf_wnum != 5'd0);

`ifdef TRACE_SHADOW_FILTER_EN
    logic [63:0] shadow_q [32];

    assign qualify = candidate && (wdata_v != shadow_q[debug_wb_rf_wnum]);

    // Shadow tracks every qualifying write, even those the FIFO drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) shadow_q[i] <= '0;
        end else if (qualify) begin
            shadow_q[debug_wb_rf_wnum] <= wdata_v;
        end
    end
`else
    assign qualify = candidate;
`endif

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop   = !empty && trace_ready;
    assign push  = qualify && (!full || pop);

    always_comb begin
        seq_d      = qualify ? seq_q + CNT_W'(1) : seq_q;
        wptr_d     = push ? wptr_q + (AW+1)'(1) : wptr_q;
        rptr_d     = pop ? rptr_q + (AW+1)'(1) : rptr_q;
        overflow_d = overflow_q || (qualify && !push);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seq_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            seq_q      <= seq_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= {debug_wb_pc[31:0], debug_wb_rf_wnum, wdata_v, seq_d};
        end
    end

    assign head = empty ? '0 : mem_q[rptr_q[AW-1:0]];

    assign trace_valid    = !empty;
    assign trace_pc       = head[RW-1 -: 32];
    assign trace_wnum     = head[RW-33 -: 5];
    assign trace_wdata    = head[CNT_W +: 64];
    assign trace_seq      = head[CNT_W-1:0];
    assign trace_overflow = overflow_q;
    assign trace_level    = wptr_q - rptr_q;
endmodule

// File: tb/tb_wb_trace_gen.sv
// Directed bench for wb_trace_gen: expected records queued at issue time, a monitor
// pops and compares each accepted record on the falling edge.
module tb_wb_trace_gen;
  localparam int DEPTH = 16;
  localparam int CNT_W = 32;
  localparam int W = 32 + 5 + 64 + CNT_W;
`ifdef TRACE_SHADOW_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic [63:0]       debug_wb_pc;
  logic [7:0]        debug_wb_rf_wen;
  logic [4:0]        debug_wb_rf_wnum;
  logic [63:0]       debug_wb_rf_wdata;
  logic              trace_valid;
  logic              trace_ready;
  logic [31:0]       trace_pc;
  logic [4:0]        trace_wnum;
  logic [63:0]       trace_wdata;
  logic [CNT_W-1:0]  trace_seq;
  logic              trace_overflow;
  logic [4:0]        trace_level;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [CNT_W-1:0] seq_m;

  wb_trace_gen #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_wnum(trace_wnum), .trace_wdata(trace_wdata),
    .trace_seq(trace_seq), .trace_overflow(trace_overflow), .trace_level(trace_level)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h req=%0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!reset && trace_valid && trace_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_record act=%0h req=none", {trace_pc, trace_wnum, trace_wdata, trace_seq});
      end else begin
        chk("record", {trace_pc, trace_wnum, trace_wdata, trace_seq}, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic idle_inputs();
    debug_wb_pc       = '0;
    debug_wb_rf_wen   = '0;
    debug_wb_rf_wnum  = '0;
    debug_wb_rf_wdata = '0;
  endtask

  task automatic wb_write(input logic [63:0] pc, input logic [7:0] wen, input logic [4:0] wnum,
                          input logic [63:0] wdata, input bit qual, input bit kept,
                          input logic [63:0] exp_wd);
    debug_wb_pc       = pc;
    debug_wb_rf_wen   = wen;
    debug_wb_rf_wnum  = wnum;
    debug_wb_rf_wdata = wdata;
    if (qual) begin
      seq_m++;
      if (kept) exp_q.push_back({pc[31:0], wnum, exp_wd, seq_m});
    end
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic drain(input string name);
    int n;
    trace_ready = 1'b1;
    n = 0;
    while (trace_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (trace_valid) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout act=valid req=empty", name);
    end
    chk({name, "_queue_left"}, W'(exp_q.size()), '0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #3;
    exp_q.delete();
    seq_m = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    idle_inputs();
    trace_ready = 1'b0;
    seq_m = '0;
    reset = 1'b1;
    #2;
    chk("rst_valid", W'(trace_valid), '0);
    chk("rst_pc", W'(trace_pc), '0);
    chk("rst_wnum", W'(trace_wnum), '0);
    chk("rst_wdata", W'(trace_wdata), '0);
    chk("rst_seq", W'(trace_seq), '0);
    chk("rst_overflow", W'(trace_overflow), '0);
    chk("rst_level", W'(trace_level), '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // first record latency: visible one cycle after the write, no bypass
    debug_wb_pc       = 64'h0000_0000_8000_0000;
    debug_wb_rf_wen   = 8'hFF;
    debug_wb_rf_wnum  = 5'd5;
    debug_wb_rf_wdata = 64'h1234;
    seq_m++;
    exp_q.push_back({32'h8000_0000, 5'd5, 64'h1234, seq_m});
    #1;
    chk("no_bypass_valid", W'(trace_valid), '0);
    @(posedge clk);
    #1;
    idle_inputs();
    chk("first_valid", W'(trace_valid), W'(1));
    chk("first_level", W'(trace_level), W'(1));
    chk("first_pc", W'(trace_pc), W'(32'h8000_0000));
    chk("first_wnum", W'(trace_wnum), W'(5));
    chk("first_wdata", W'(trace_wdata), W'(64'h1234));
    chk("first_seq", W'(trace_seq), W'(1));
    drain("first");

    // byte masking and non-candidates
    wb_write(64'h8000_0004, 8'h0F, 5'd3, 64'hFFFF_FFFF_AABB_CCDD, 1, 1, 64'h0000_0000_AABB_CCDD);
    wb_write(64'h8000_0008, 8'hFF, 5'd0, 64'h55, 0, 0, '0);
    wb_write(64'h8000_000C, 8'h00, 5'd4, 64'h77, 0, 0, '0);
    wb_write(64'h8000_0010, 8'hA5, 5'd9, 64'h1122_3344_5566_7788, 1, 1, 64'h1100_3300_0066_0088);
    drain("mask");
    chk("mask_level", W'(trace_level), '0);

    // repeated value to the same register, back to back
    wb_write(64'h8000_0014, 8'hFF, 5'd7, 64'h10, 1, 1, 64'h10);
    wb_write(64'h8000_0018, 8'hFF, 5'd7, 64'h10, !FILT, !FILT, 64'h10);
    wb_write(64'h8000_001C, 8'hFF, 5'd7, 64'h20, 1, 1, 64'h20);
    drain("shadow");

    // overflow: 20 writes into a stalled FIFO of 16
    do_reset();
    trace_ready = 1'b0;
    for (int i = 1; i <= 20; i++)
      wb_write(64'h8000_1000 + 64'(4*i), 8'hFF, 5'(i), 64'h100 + 64'(i), 1, i <= 16, 64'h100 + 64'(i));
    chk("ovf_level", W'(trace_level), W'(16));
    chk("ovf_flag", W'(trace_overflow), W'(1));
    drain("ovf");
    wb_write(64'h8000_2000, 8'hFF, 5'd21, 64'h500, 1, 1, 64'h500);
    drain("ovf_next");
    chk("ovf_sticky", W'(trace_overflow), W'(1));

    // full FIFO with simultaneous push and pop
    do_reset();
    trace_ready = 1'b0;
    for (int i = 1; i <= 16; i++)
      wb_write(64'h8000_3000 + 64'(4*i), 8'hFF, 5'(i), 64'h200 + 64'(i), 1, 1, 64'h200 + 64'(i));
    chk("full_level", W'(trace_level), W'(16));
    chk("full_overflow", W'(trace_overflow), '0);
    trace_ready = 1'b1;
    wb_write(64'h8000_3100, 8'hFF, 5'd17, 64'h300, 1, 1, 64'h300);
    trace_ready = 1'b0;
    chk("pushpop_level", W'(trace_level), W'(16));
    chk("pushpop_overflow", W'(trace_overflow), '0);
    drain("pushpop");

    // asynchronous reset with records queued
    trace_ready = 1'b0;
    for (int i = 1; i <= 4; i++)
      wb_write(64'h8000_4000 + 64'(4*i), 8'hFF, 5'(i), 64'h40 + 64'(i), 1, 1, 64'h40 + 64'(i));
    wb_write(64'h8000_4020, 8'hFF, 5'd5, 64'hABCD, 1, 1, 64'hABCD);
    chk("pre_rst_level", W'(trace_level), W'(5));
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_valid", W'(trace_valid), '0);
    chk("midrst_level", W'(trace_level), '0);
    chk("midrst_seq", W'(trace_seq), '0);
    exp_q.delete();
    seq_m = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    trace_ready = 1'b1;
    wb_write(64'h8000_5000, 8'hFF, 5'd5, 64'hABCD, 1, 1, 64'hABCD);
    wb_write(64'h8000_5004, 8'hFF, 5'd6, 64'h0, !FILT, !FILT, 64'h0);
    wb_write(64'h8000_5008, 8'hFF, 5'd8, 64'h88, 1, 1, 64'h88);
    drain("post_rst");
    chk("end_level", W'(trace_level), '0);
    chk("end_overflow", W'(trace_overflow), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
